// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default parameters and
// counter sizing helpers.
package reset_seq_pkg;

  localparam int unsigned DefNStages      = 3;
  localparam int unsigned DefStableCycles = 16;
  localparam int unsigned DefStageGap     = 8;
  localparam int unsigned DefDoneTimeout  = 1024;

  typedef logic [2:0] state_t;

  localparam state_t StWaitLock = 3'd0;
  localparam state_t StStable   = 3'd1;
  localparam state_t StRelease  = 3'd2;
  localparam state_t StWaitDone = 3'd3;
  localparam state_t StGap      = 3'd4;
  localparam state_t StRun      = 3'd5;
  localparam state_t StFault    = 3'd6;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit above the largest limit so a saturated counter never aliases a limit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the clk_i domain.
module sync_2ff
  import reset_seq_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets one at a time, in index order, once the clock lock has been
// stable; flags a sticky fault if a domain never reports init_done.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES      = DefNStages,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned STAGE_GAP     = DefStageGap,
  parameter int unsigned DONE_TIMEOUT  = DefDoneTimeout
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic [N_STAGES-1:0] init_done,
  output logic [N_STAGES-1:0] stage_reset,
  output logic                all_ready,
  output logic                fault,
  output logic [2:0]          fault_stage
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, STAGE_GAP, DONE_TIMEOUT);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       StableLast  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t       GapLast     = cnt_t'(STAGE_GAP - 1);
  localparam cnt_t       TimeoutLast = cnt_t'(DONE_TIMEOUT - 1);
  localparam logic [2:0] LastStage   = 3'(N_STAGES - 1);

  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                lock_s;
  logic [7:0]          done_pad;
  state_t              state_q, state_d;
  cnt_t                cnt_q, cnt_d;
  logic [2:0]          k_q, k_d;
  logic [N_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                all_ready_q, all_ready_d;
  logic                fault_q, fault_d;
  logic [2:0]          fault_stage_q, fault_stage_d;

  sync_2ff #(
    .Width (1)
  ) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (locked),
    .q_o    (lock_s)
  );

  // Padding lets k index init_done without an out-of-range select for small N_STAGES.
  assign done_pad = 8'(init_done);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    stage_reset_d = stage_reset_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    if (state_q != StFault && !lock_s) begin
      state_d       = StWaitLock;
      cnt_d         = '0;
      k_d           = '0;
      stage_reset_d = '1;
      all_ready_d   = 1'b0;
    end else begin
      case (state_q)
        StWaitLock: begin
          stage_reset_d = '1;
          all_ready_d   = 1'b0;
          cnt_d         = '0;
          state_d       = StStable;
        end
        StStable: begin
          if (cnt_q >= StableLast) begin
            cnt_d   = '0;
            k_d     = '0;
            state_d = StRelease;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        StRelease: begin
          for (int unsigned i = 0; i < N_STAGES; i++) begin
            if (3'(i) == k_q) stage_reset_d[i] = 1'b0;
          end
          cnt_d   = '0;
          state_d = StWaitDone;
        end
        StWaitDone: begin
          // A done arriving on the timeout cycle still counts as done.
          if (done_pad[k_q]) begin
            cnt_d = '0;
            if (k_q >= LastStage) begin
              all_ready_d = 1'b1;
              state_d     = StRun;
            end else begin
              k_d     = k_q + 3'd1;
              state_d = (STAGE_GAP == 0) ? StRelease : StGap;
            end
          end else if (cnt_q >= TimeoutLast) begin
            fault_d       = 1'b1;
            fault_stage_d = k_q;
            for (int unsigned i = 0; i < N_STAGES; i++) begin
              if (3'(i) >= k_q) stage_reset_d[i] = 1'b1;
            end
            state_d = StFault;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        StGap: begin
          if (cnt_q >= GapLast) begin
            cnt_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        StRun: begin
          all_ready_d = 1'b1;
        end
        StFault: begin
          // Sticky until rst_n; lock changes are deliberately ignored here.
        end
        default: begin
          state_d       = StWaitLock;
          cnt_d         = '0;
          k_d           = '0;
          stage_reset_d = '1;
          all_ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StWaitLock;
      cnt_q         <= '0;
      k_q           <= '0;
      stage_reset_q <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      k_q           <= k_d;
      stage_reset_q <= stage_reset_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign all_ready   = all_ready_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, 3, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, 16, consecutive synchronized-lock cycles required before sequencing (>=1).
REQ-003 SHALL have parameter STAGE_GAP, 8, idle cycles between one stage's init_done and the next stage's release (>=0).
REQ-004 SHALL have parameter DONE_TIMEOUT, 1024, maximum cycles from a stage release to its init_done.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port locked  input  1  clock-wizard lock, asynchronous to clk.
REQ-008 SHALL have port init_done  input  N_STAGES  per-stage initialization-complete level, bit i from domain i.
REQ-009 SHALL have port stage_reset  output  N_STAGES  per-stage reset, active-high, registered.
REQ-010 SHALL have port all_ready  output  1  high while every stage is released and done.
REQ-011 SHALL have port fault  output  1  sticky timeout indication.
REQ-012 SHALL have port fault_stage  output  3  index of the stage that timed out.

Function
REQ-013 SHALL synchronize locked through two flops; lock_s denotes the second-flop output; all decisions use lock_s only.
REQ-014 SHALL implement FSM states WAIT_LOCK, STABLE, RELEASE, WAIT_DONE, GAP, RUN, FAULT.
REQ-015 WAIT_LOCK: all stage_reset high; lock_s=1 -> STABLE with counter cleared.
REQ-016 STABLE: counter increments each cycle lock_s=1; on reaching STABLE_CYCLES -> RELEASE with stage index k=0.
REQ-017 RELEASE: one cycle; stage_reset[k] driven low from the next edge and held low; timeout counter cleared; -> WAIT_DONE.
REQ-018 WAIT_DONE: init_done[k]=1 -> GAP if k<N_STAGES-1 (k increments), else RUN; timeout counter reaching DONE_TIMEOUT first -> FAULT.
REQ-019 init_done[k] and timeout in the same cycle SHALL resolve as done (done wins).
REQ-020 GAP: waits STAGE_GAP cycles then -> RELEASE; STAGE_GAP=0 SHALL go directly to RELEASE.
REQ-021 Stages SHALL be released strictly in index order, never two in the same cycle; released stages stay released until loss of lock or reset.
REQ-022 init_done bits of unreleased stages SHALL be ignored.
REQ-023 RUN: all_ready=1; init_done deassertion SHALL NOT affect state.
REQ-024 lock_s=0 in any state other than FAULT SHALL force all stage_reset high, clear counters and k, and enter WAIT_LOCK on the next edge.
REQ-025 FAULT: fault=1, fault_stage=k; stage_reset[k] and all higher stages driven high, lower stages stay released; exit only via rst_n.
REQ-026 Counters SHALL be sized $clog2(max parameter)+1 and SHALL saturate, never wrap.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state=WAIT_LOCK, stage_reset=all ones, all_ready=0, fault=0, fault_stage=0, counters=0, k=0, synchronizer flops=0.
REQ-028 Reset asserted mid-sequence SHALL restart the full sequence, including STABLE_CYCLES qualification.

Structure
REQ-029 Shared package reset_seq_pkg SHALL hold the state enum and default parameter constants.
REQ-030 The two-flop synchronizer SHALL be a separate sub-module sync_2ff, reused by other clock-domain inputs.

Verification
REQ-031 rst_n low 3 cycles, locked=1, init_done immediately high on release -> stage_reset[0] falls STABLE_CYCLES+2 sync +1 cycles after lock is seen; stages 1,2 each fall STAGE_GAP+2 cycles later; all_ready=1 after stage 2 done.
REQ-032 locked glitches low for 1 cycle at STABLE count 10 -> counter restarts, no stage released until 16 consecutive lock_s cycles.
REQ-033 init_done[1] never asserted -> fault=1, fault_stage=1 exactly DONE_TIMEOUT cycles after stage 1 release; stage_reset=3'b110 held until rst_n.
REQ-034 locked drops while in RUN -> stage_reset=3'b111 within 3 cycles (2 sync + 1), all_ready=0, then full resequence on relock.
REQ-035 init_done[2] asserted before stage 2 release -> ignored; stage 2 still released only after GAP; done at timeout boundary cycle -> RUN, no fault.
REQ-036 rst_n asserted during WAIT_DONE of stage 1 -> next cycle all outputs at reset values.
